// File: rtl/display_mode_controller_if.sv
// ALU result handshake: the ALU (master) offers a result, the controller
// (slave) accepts it when ready is high.
interface display_mode_controller_if;
   logic        valid;
   logic        ready;
   logic [15:0] result;
   logic        error;

   modport master (output valid, output result, output error, input ready);
   modport slave  (input valid, input result, input error, output ready);
endinterface

// File: rtl/display_mode_controller.sv
// Display mode sequencer: picks CLOCK, CALC or ERROR view for the 8-digit
// display, latches ALU results, and times out back to the clock view.
module display_mode_controller #(
   parameter int TICK_DIV        = 50000,
   parameter int CALC_HOLD_TICKS = 5000,
   parameter int ERR_HOLD_TICKS  = 2000
) (
   input  logic                             clk,
   input  logic                             rst_n,
   display_mode_controller_if.slave         calc,
   input  logic                             mode_btn_i,
   output logic [1:0]                       mode_o,
   output logic [15:0]                      disp_result_o,
   output logic                             disp_sign_o,
   output logic                             disp_error_o
);

   localparam int HMAX   = (CALC_HOLD_TICKS > ERR_HOLD_TICKS) ? CALC_HOLD_TICKS : ERR_HOLD_TICKS;
   localparam int HOLD_W = $clog2(HMAX + 1);
   localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [HOLD_W-1:0] CALC_HOLD = HOLD_W'(CALC_HOLD_TICKS);
   localparam logic [HOLD_W-1:0] ERR_HOLD  = HOLD_W'(ERR_HOLD_TICKS);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);

   // Encodings double as the mode output so mode_o comes straight off a flop.
   typedef enum logic [1:0] {
      ST_CALC  = 2'b00,
      ST_CLOCK = 2'b01,
      ST_ERROR = 2'b11
   } state_t;

   state_t            state_q;
   logic              ready_q;
   logic [HOLD_W-1:0] hold_q;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic              btn_q;
   logic [15:0]       result_q;
   logic              sign_q;
   logic              error_q;

   logic tick, xfer, btn_rise, expire;

   assign tick     = (presc_q == PRE_LAST);
   assign xfer     = calc.valid && ready_q;
   assign btn_rise = mode_btn_i && !btn_q;
   assign expire   = tick && (hold_q == HOLD_W'(1));
   assign presc_d  = tick ? '0 : presc_q + PRE_W'(1);

   assign calc.ready    = ready_q;
   assign mode_o        = state_q;
   assign disp_result_o = result_q;
   assign disp_sign_o   = sign_q;
   assign disp_error_o  = error_q;

   // Free-running timeout prescaler; unaffected by view changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // View FSM with registered outputs; transfer beats button beats expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_CLOCK;
         ready_q  <= 1'b1;
         hold_q   <= '0;
         btn_q    <= 1'b0;
         result_q <= '0;
         sign_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         btn_q <= mode_btn_i;
         unique case (state_q)
            ST_CLOCK, ST_CALC: begin
               if (xfer) begin
                  if (calc.error) begin
                     // Keep the last good result on screen behind the banner.
                     state_q <= ST_ERROR;
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                     hold_q  <= ERR_HOLD;
                  end else begin
                     state_q  <= ST_CALC;
                     result_q <= calc.result;
                     sign_q   <= calc.result[15];
                     hold_q   <= CALC_HOLD;
                  end
               end else if (state_q == ST_CLOCK) begin
                  if (btn_rise) begin
                     state_q <= ST_CALC;
                     hold_q  <= CALC_HOLD;
                  end
               end else if (btn_rise || expire) begin
                  state_q <= ST_CLOCK;
                  hold_q  <= '0;
               end else if (tick && hold_q != '0) begin
                  hold_q <= hold_q - HOLD_W'(1);
               end
            end
            ST_ERROR: begin
               if (btn_rise || expire) begin
                  state_q <= ST_CLOCK;
                  error_q <= 1'b0;
                  ready_q <= 1'b1;
                  hold_q  <= '0;
               end else if (tick && hold_q != '0) begin
                  hold_q <= hold_q - HOLD_W'(1);
               end
            end
            default: begin
               // 2'b10 is unreachable; recover to the clock view.
               state_q <= ST_CLOCK;
               error_q <= 1'b0;
               ready_q <= 1'b1;
               hold_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_mode_controller.sv
// Scoreboard bench for display_mode_controller: stimulus queues expected
// output snapshots tagged with the cycle they apply to; a negedge monitor
// pops and compares them.
module tb_display_mode_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mode_btn = 1'b0;
   logic [1:0]  mode;
   logic [15:0] disp_result;
   logic        disp_sign;
   logic        disp_error;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   display_mode_controller_if calc_if ();

   display_mode_controller #(
      .TICK_DIV(4),
      .CALC_HOLD_TICKS(3),
      .ERR_HOLD_TICKS(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .calc         (calc_if.slave),
      .mode_btn_i   (mode_btn),
      .mode_o       (mode),
      .disp_result_o(disp_result),
      .disp_sign_o  (disp_sign),
      .disp_error_o (disp_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [1:0]  mode;
      logic [15:0] res;
      logic        sign;
      logic        err;
      logic        rdy;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Monitor: compare every snapshot due at or before this cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({mode, disp_result, disp_sign, disp_error, calc_if.ready} !==
             {mon_e.mode, mon_e.res, mon_e.sign, mon_e.err, mon_e.rdy}) begin
            errors++;
            $display("FAIL %s @cyc %0d: got mode=%b res=%h sign=%b err=%b rdy=%b, want mode=%b res=%h sign=%b err=%b rdy=%b",
                     mon_e.name, cyc, mode, disp_result, disp_sign, disp_error, calc_if.ready,
                     mon_e.mode, mon_e.res, mon_e.sign, mon_e.err, mon_e.rdy);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input logic [1:0] m, input logic [15:0] r, input logic s,
                             input logic e, input logic rdy, input string name);
      exp_t x;
      x.cyc = cyc; x.mode = m; x.res = r; x.sign = s; x.err = e; x.rdy = rdy; x.name = name;
      exp_q.push_back(x);
   endtask

   task automatic offer(input logic [15:0] r, input logic e);
      calc_if.valid  = 1'b1;
      calc_if.result = r;
      calc_if.error  = e;
   endtask

   task automatic idle();
      calc_if.valid  = 1'b0;
      calc_if.result = '0;
      calc_if.error  = 1'b0;
   endtask

   // Cycles from acceptance until the clock view returns must fall in [lo,hi].
   task automatic wait_clock(input int n0, input int lo, input int hi, input string name);
      int n;
      n = n0;
      while (mode !== 2'b01 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n < lo || n > hi) begin
         errors++;
         $display("FAIL %s: return to CLOCK after %0d cycles, want %0d..%0d", name, n, lo, hi);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      step(); step();
      expect_now(2'b01, 16'h0000, 0, 0, 1, "reset_state");
      rst_n = 1'b1;
      step();

      // Negative result, then idle timeout back to CLOCK.
      offer(16'hFFF6, 0); step(); idle();
      expect_now(2'b00, 16'hFFF6, 1, 0, 1, "neg_result");
      wait_clock(0, 9, 12, "calc_timeout");
      expect_now(2'b01, 16'hFFF6, 1, 0, 1, "after_calc_timeout");

      // Error transfer; offer during ERROR is dropped; error timeout.
      offer(16'h1234, 1); step(); idle();
      expect_now(2'b11, 16'hFFF6, 1, 1, 0, "error_enter");
      offer(16'h0005, 0); step(); idle();
      expect_now(2'b11, 16'hFFF6, 1, 1, 0, "valid_ignored_in_error");
      wait_clock(1, 5, 8, "error_timeout");
      expect_now(2'b01, 16'hFFF6, 1, 0, 1, "after_error_timeout");

      // Latch 0x0005 and let it time out.
      offer(16'h0005, 0); step(); idle();
      expect_now(2'b00, 16'h0005, 0, 0, 1, "latch_0005");
      wait_clock(0, 9, 12, "calc_timeout2");

      // Button toggles CLOCK -> CALC -> CLOCK.
      mode_btn = 1; step();
      expect_now(2'b00, 16'h0005, 0, 0, 1, "btn_to_calc");
      mode_btn = 0; step();
      expect_now(2'b00, 16'h0005, 0, 0, 1, "btn_level_low");
      mode_btn = 1; step();
      expect_now(2'b01, 16'h0005, 0, 0, 1, "btn_to_clock");
      mode_btn = 0; step();

      // Button acknowledges an error.
      offer(16'h0000, 1); step(); idle();
      expect_now(2'b11, 16'h0005, 0, 1, 0, "error_enter2");
      mode_btn = 1; step();
      expect_now(2'b01, 16'h0005, 0, 0, 1, "btn_ack_error");
      mode_btn = 0; step();

      // Transfer and button in the same cycle while in CALC.
      mode_btn = 1; step();
      expect_now(2'b00, 16'h0005, 0, 0, 1, "btn_to_calc2");
      mode_btn = 0; step();
      offer(16'h0007, 0); mode_btn = 1; step(); idle(); mode_btn = 0;
      expect_now(2'b00, 16'h0007, 0, 0, 1, "xfer_beats_btn");
      wait_clock(0, 9, 12, "reload_timeout");

      // Back-to-back transfers.
      offer(16'h0001, 0); step();
      expect_now(2'b00, 16'h0001, 0, 0, 1, "b2b_1");
      offer(16'h0002, 0); step();
      expect_now(2'b00, 16'h0002, 0, 0, 1, "b2b_2");
      offer(16'h0003, 0); step(); idle();
      expect_now(2'b00, 16'h0003, 0, 0, 1, "b2b_3");
      wait_clock(0, 9, 12, "b2b_timeout");

      // Most-negative value is latched unmodified.
      offer(16'h8000, 0); step(); idle();
      expect_now(2'b00, 16'h8000, 1, 0, 1, "most_negative");

      // Asynchronous reset mid-CALC.
      offer(16'h0123, 0); step(); idle();
      expect_now(2'b00, 16'h0123, 0, 0, 1, "latch_0123");
      step();
      rst_n = 1'b0; #1;
      expect_now(2'b01, 16'h0000, 0, 0, 1, "async_reset");
      step();
      rst_n = 1'b1;
      offer(16'h0042, 0); step(); idle();
      expect_now(2'b00, 16'h0042, 0, 0, 1, "first_after_reset");

      step(); step();
      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_mode_controller.md
# display_mode_controller

Sequencing controller in front of the display subsystem. It decides which view drives the 8-digit display: the running clock, the latest calculator result, or an error banner. It accepts ALU results over a valid/ready handshake and latches them for display. It returns to the clock view after an idle timeout and holds error indications for a fixed time. All outputs are registered and feed the display subsystem's mode and result inputs directly.

## Interface
- TICK_DIV, 50000: clk cycles per timeout tick (1 ms at 50 MHz); must be ≥ 2
- CALC_HOLD_TICKS, 5000: ticks the CALC view persists after the last result or entry
- ERR_HOLD_TICKS, 2000: ticks the ERROR view persists
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- calc_valid  in  1  ALU result offered this cycle
- calc_ready  out  1  controller can accept a result
- calc_result  in  16  signed ALU result, two's complement
- calc_error  in  1  ALU error flag, qualified by calc_valid
- mode_btn  in  1  debounced, synchronous user mode button (level)
- mode  out  2  display mode: 00 CALC, 01 CLOCK, 11 ERROR; 10 is never driven
- disp_result  out  16  latched result for display
- disp_sign  out  1  sign of disp_result (always equals disp_result[15])
- disp_error  out  1  error flag for display; high only in ERROR

## Operation
- Reset values:
  - state CLOCK, mode=01
  - disp_result=0, disp_sign=0, disp_error=0
  - calc_ready=1
  - prescaler=0, hold counter=0, btn_q=0
- Transfer occurs when calc_valid && calc_ready. calc_valid while calc_ready=0 is ignored; the result is dropped and never queued.
- calc_ready=1 in CLOCK and CALC; calc_ready=0 in ERROR.
- Button event is btn_rise = mode_btn && !btn_q, where btn_q is the previous-cycle mode_btn.
- Transfer without error:
  - disp_result ← calc_result, disp_sign ← calc_result[15].
  - Next state CALC; hold counter ← CALC_HOLD_TICKS.
- Transfer with error:
  - disp_result and disp_sign are unchanged; disp_error ← 1.
  - Next state ERROR; hold counter ← ERR_HOLD_TICKS.
- CLOCK state:
  - Transfer → CALC or ERROR, as above.
  - Otherwise, btn_rise → CALC, showing the last latched disp_result; hold counter ← CALC_HOLD_TICKS.
- CALC state:
  - Transfer without error stays in CALC and reloads the hold counter.
  - Transfer with error → ERROR.
  - Otherwise, btn_rise → CLOCK.
  - Otherwise, hold expiry → CLOCK.
- ERROR state:
  - btn_rise acknowledges the error → CLOCK.
  - Hold expiry → CLOCK.
  - disp_error is cleared on exit.
- Priority when events coincide in one cycle: transfer > btn_rise > hold expiry. A btn_rise in the same cycle as a transfer is discarded, not deferred.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; tick pulses for one cycle when the count equals TICK_DIV-1, then wraps to 0.
  - It is never reset by state changes.
- Hold counter:
  - Decrements on each tick while nonzero in CALC or ERROR.
  - Expiry is the tick that takes it from 1 to 0.
  - A reload in the same cycle as a tick takes the reload value; no decrement is applied that cycle.
- Negative-most value 0x8000 is latched unmodified; magnitude handling belongs to the display.

## Timing
- Transfer at edge N: mode, disp_result, disp_sign and disp_error show new values after edge N; calc_ready changes after the same edge.
- btn_rise: mode_btn rising before edge N changes mode after edge N (btn_q compare is in the same cycle).
- Dwell from entry to expiry is between (HOLD-1)·TICK_DIV+1 and HOLD·TICK_DIV cycles, depending on prescaler phase.
- Asynchronous reset mid-operation:
  - Forces the reset values immediately.
  - A transfer coincident with reset assertion is lost.
  - First acceptance is possible on the first clk edge after deassertion.

## Test plan
All scenarios use TICK_DIV=4, CALC_HOLD_TICKS=3, ERR_HOLD_TICKS=2.
- Reset → mode=01, disp_result=0, disp_sign=0, disp_error=0, calc_ready=1. Asserting rst_n=0 while in CALC with disp_result=0x0123 returns all outputs to these values before the next clk edge.
- Valid pulse with calc_result=0xFFF6 (−10), error=0 → next cycle mode=00, disp_result=0xFFF6, disp_sign=1. With no further activity, mode returns to 01 within 9 to 12 cycles after acceptance.
- Valid with calc_error=1 → mode=11, disp_error=1, calc_ready=0, disp_result unchanged. A valid pulse of 0x0005 during ERROR is ignored. mode returns to 01 within 5 to 8 cycles after acceptance, with disp_error=0.
- In CLOCK, mode_btn rises → mode=00, showing the previously latched 0x0005. A second rise → mode=01. A rise during ERROR → mode=01 the next cycle.
- Same-cycle valid (0x0007, no error) and mode_btn rise while in CALC → mode stays 00, disp_result=0x0007, and the hold timer is reloaded so the CALC view lasts at least 9 more cycles.
- Back-to-back valid pulses on every cycle (0x0001, 0x0002, 0x0003) → disp_result follows each with 1-cycle latency. Hold expiry occurs 9 to 12 cycles after the last pulse.
